// File: rtl/sram_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_stream_pkg
//  Description : Shared constants for the dual-port sector buffer engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_stream_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic DIR_OUT = 1'b0;
    localparam logic DIR_IN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sram_dp_core.sv
`default_nettype none
// ============================================================================
//  Module      : sram_dp_core
//  Description : True dual-port synchronous RAM, read-old-data, port A wins
//                simultaneous writes to the same address.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_dp_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_we,
    input  logic              a_re,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_we,
    input  logic              b_re,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              b_we_eff;

    always_comb begin
        b_we_eff  = b_we && !(a_we && (a_addr == b_addr));
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        if (a_re) a_rdata_d = mem[a_addr];
        if (b_re) b_rdata_d = mem[b_addr];
    end

    // Array is never reset; reads sample pre-edge contents (read-old-data).
    always_ff @(posedge clk) begin
        if (a_we)     mem[a_addr] <= a_wdata;
        if (b_we_eff) mem[b_addr] <= b_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule
`default_nettype wire

// File: rtl/sram_dp_stream.sv
`default_nettype none
// ============================================================================
//  Module      : sram_dp_stream
//  Description : Dual-port sector buffer: host random access on port A and a
//                valid/ready burst streaming engine on port B.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_dp_stream
    import sram_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    input  logic              a_rw,
    input  logic              a_en,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_valid,
    input  logic              b_start,
    input  logic              b_dir,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W:0]   b_len,
    input  logic              b_abort,
    output logic [DATA_W-1:0] b_out_data,
    output logic              b_out_valid,
    input  logic              b_out_ready,
    input  logic [DATA_W-1:0] b_in_data,
    input  logic              b_in_valid,
    output logic              b_in_ready,
    output logic              b_busy,
    output logic              b_done
);

    localparam int CNT_W = ADDR_W + 1;

    logic [1:0]             state_q, state_d;
    logic                   dir_q, dir_d;
    logic [ADDR_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]       reads_q, reads_d;
    logic [CNT_W-1:0]       remain_q, remain_d;
    logic                   inflight_q, inflight_d;
    logic [1:0][DATA_W-1:0] fifo_q, fifo_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   a_valid_q, a_valid_d;

    logic                   a_re, a_we;
    logic [DATA_W-1:0]      b_rdata;
    logic                   in_fire, pop, push, issue;
    logic [2:0]             occ;

    assign a_re       = !a_en && a_rw;
    assign a_we       = !a_en && !a_rw;
    assign b_in_ready = (state_q == ST_RUN) && (dir_q == DIR_IN);
    assign b_out_valid = (cnt_q != 2'd0);
    assign b_out_data = fifo_q[rd_ptr_q];
    assign b_busy     = (state_q != ST_IDLE);
    assign b_done     = done_q;
    assign a_valid    = a_valid_q;

    assign in_fire = b_in_ready && b_in_valid;
    assign pop     = b_out_valid && b_out_ready;
    assign push    = inflight_q;
    // Counting the same-cycle pop lets a new read overlap the drain: no bubbles.
    assign occ     = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue   = (state_q == ST_RUN) && (dir_q == DIR_OUT) &&
                     (reads_q != '0) && (occ < 3'd2);

    sram_dp_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_we    (a_we),
        .a_re    (a_re),
        .a_addr  (a_addr),
        .a_wdata (a_din),
        .a_rdata (a_dout),
        .b_we    (in_fire),
        .b_re    (issue),
        .b_addr  (ptr_q),
        .b_wdata (b_in_data),
        .b_rdata (b_rdata)
    );

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        ptr_d      = ptr_q;
        reads_d    = reads_q;
        remain_d   = remain_q;
        inflight_d = issue;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
        done_d     = 1'b0;
        a_valid_d  = a_re;

        if (push) begin
            fifo_d[wr_ptr_q] = b_rdata;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop)              rd_ptr_d = ~rd_ptr_q;
        if (issue || in_fire) ptr_d    = ptr_q + ADDR_W'(1);
        if (issue)            reads_d  = reads_q - CNT_W'(1);
        if (pop || in_fire)   remain_d = remain_q - CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (b_start) begin
                    if (b_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = ST_RUN;
                        dir_d    = b_dir;
                        ptr_d    = b_base;
                        reads_d  = b_len;
                        remain_d = b_len;
                    end
                end
            end
            ST_RUN: begin
                if (issue && (reads_q == CNT_W'(1))) state_d = ST_DRAIN;
                if (in_fire && (remain_q == CNT_W'(1))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (pop && (remain_q == CNT_W'(1))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort discards buffered and in-flight words; the current handshake stands.
        if (b_abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            done_d     = 1'b0;
            cnt_d      = 2'd0;
            inflight_d = 1'b0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_OUT;
            ptr_q      <= '0;
            reads_q    <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
            fifo_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            done_q     <= 1'b0;
            a_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            ptr_q      <= ptr_d;
            reads_q    <= reads_d;
            remain_q   <= remain_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            a_valid_q  <= a_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_dp_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_dp_stream
//  Description : Scoreboard bench for the dual-port sector buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_dp_stream;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 13;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_din;
    logic              a_rw;
    logic              a_en;
    logic [DATA_W-1:0] a_dout;
    logic              a_valid;
    logic              b_start;
    logic              b_dir;
    logic [ADDR_W-1:0] b_base;
    logic [ADDR_W:0]   b_len;
    logic              b_abort;
    logic [DATA_W-1:0] b_out_data;
    logic              b_out_valid;
    logic              b_out_ready;
    logic [DATA_W-1:0] b_in_data;
    logic              b_in_valid;
    logic              b_in_ready;
    logic              b_busy;
    logic              b_done;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] sb[$];

    always #5 clk = ~clk;

    sram_dp_stream #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_addr(a_addr), .a_din(a_din), .a_rw(a_rw), .a_en(a_en),
        .a_dout(a_dout), .a_valid(a_valid),
        .b_start(b_start), .b_dir(b_dir), .b_base(b_base), .b_len(b_len),
        .b_abort(b_abort),
        .b_out_data(b_out_data), .b_out_valid(b_out_valid), .b_out_ready(b_out_ready),
        .b_in_data(b_in_data), .b_in_valid(b_in_valid), .b_in_ready(b_in_ready),
        .b_busy(b_busy), .b_done(b_done)
    );

    task automatic a_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        a_en = 1'b0; a_rw = 1'b0; a_addr = addr; a_din = data;
        @(negedge clk);
        a_en = 1'b1; a_rw = 1'b1;
    endtask

    task automatic a_read(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] data,
                          output logic vld);
        a_en = 1'b0; a_rw = 1'b1; a_addr = addr;
        @(negedge clk);
        data = a_dout; vld = a_valid;
        a_en = 1'b1;
    endtask

    task automatic start_burst(input logic dir, input logic [ADDR_W-1:0] base,
                               input logic [ADDR_W:0] len);
        b_dir = dir; b_base = base; b_len = len; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_dout, a_valid, b_out_data, b_out_valid, b_in_ready, b_busy, b_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got a_dout=%h a_valid=%b out_data=%h out_valid=%b in_ready=%b busy=%b done=%b required all 0",
                     a_dout, a_valid, b_out_data, b_out_valid, b_in_ready, b_busy, b_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_port_a();
        logic [DATA_W-1:0] d; logic v;
        a_write(13'h1FFF, 8'h5A);
        a_read(13'h1FFF, d, v);
        checks++;
        if (v !== 1'b1 || d !== 8'h5A) begin
            errors++; $display("FAIL porta_read got valid=%b data=%h required 1 5a", v, d);
        end
        @(negedge clk);
        checks++;
        if (a_valid !== 1'b0 || a_dout !== 8'h5A) begin
            errors++; $display("FAIL porta_hold got valid=%b data=%h required 0 5a", a_valid, a_dout);
        end
        a_write(13'h0000, 8'h11);
        a_write(13'h0001, 8'h22);
        sb.push_back(8'h11); sb.push_back(8'h22);
        a_en = 1'b0; a_rw = 1'b1; a_addr = 13'h0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a_addr = 13'h0001;
            d = sb.pop_front();
            checks++;
            if (a_valid !== 1'b1 || a_dout !== d) begin
                errors++; $display("FAIL porta_b2b%0d got valid=%b data=%h required 1 %h", i, a_valid, a_dout, d);
            end
        end
        a_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        start_burst(1'b0, 13'h0040, '0);
        checks++;
        if (b_done !== 1'b1 || b_busy !== 1'b0) begin
            errors++; $display("FAIL zero_len got done=%b busy=%b required 1 0", b_done, b_busy);
        end
        @(negedge clk);
        checks++;
        if (b_done !== 1'b0) begin
            errors++; $display("FAIL zero_len_pulse got done=%b required 0", b_done);
        end
    endtask

    task automatic test_out_burst();
        logic [DATA_W-1:0] e;
        for (int i = 0; i < 16; i++) a_write(ADDR_W'(13'h10 + i), DATA_W'(i));
        for (int i = 0; i < 16; i++) sb.push_back(DATA_W'(i));
        b_out_ready = 1'b1;
        start_burst(1'b0, 13'h0010, 14'd16);
        checks++;
        if (b_busy !== 1'b1 || b_out_valid !== 1'b0) begin
            errors++; $display("FAIL out_start got busy=%b valid=%b required 1 0", b_busy, b_out_valid);
        end
        @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b0) begin
            errors++; $display("FAIL out_latency got valid=%b required 0", b_out_valid);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (b_out_valid !== 1'b1 || b_out_data !== e || b_done !== 1'b0) begin
                errors++; $display("FAIL out_word%0d got valid=%b data=%h done=%b required 1 %h 0",
                                   i, b_out_valid, b_out_data, b_done, e);
            end
        end
        @(negedge clk);
        checks++;
        if (b_done !== 1'b1 || b_busy !== 1'b0 || b_out_valid !== 1'b0) begin
            errors++; $display("FAIL out_done got done=%b busy=%b valid=%b required 1 0 0", b_done, b_busy, b_out_valid);
        end
        @(negedge clk);
        checks++;
        if (b_done !== 1'b0) begin
            errors++; $display("FAIL out_done_pulse got done=%b required 0", b_done);
        end
    endtask

    task automatic test_out_backpressure();
        logic [DATA_W-1:0] e, last; logic stalled; int cyc;
        for (int i = 0; i < 16; i++) sb.push_back(DATA_W'(i));
        b_out_ready = 1'b0;
        start_burst(1'b0, 13'h0010, 14'd16);
        stalled = 1'b0; last = '0; cyc = 0;
        while (sb.size() != 0 && cyc < 400) begin
            b_out_ready = 1'($urandom_range(0, 1));
            if (stalled) begin
                checks++;
                if (b_out_valid !== 1'b1 || b_out_data !== last) begin
                    errors++; $display("FAIL bp_hold got valid=%b data=%h required 1 %h", b_out_valid, b_out_data, last);
                end
            end
            checks++;
            if (b_done !== 1'b0) begin
                errors++; $display("FAIL bp_early_done got done=%b required 0", b_done);
            end
            if (b_out_valid && b_out_ready) begin
                e = sb.pop_front();
                checks++;
                if (b_out_data !== e) begin
                    errors++; $display("FAIL bp_word got data=%h required %h", b_out_data, e);
                end
            end
            stalled = b_out_valid && !b_out_ready;
            last = b_out_data;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL bp_timeout got %0d words left required 0", sb.size());
            sb.delete();
        end
        b_out_ready = 1'b1;
        checks++;
        if (b_done !== 1'b1 || b_busy !== 1'b0) begin
            errors++; $display("FAIL bp_done got done=%b busy=%b required 1 0", b_done, b_busy);
        end
        @(negedge clk);
    endtask

    task automatic test_in_wrap();
        logic [DATA_W-1:0] d; logic v;
        start_burst(1'b1, 13'h1FFE, 14'd4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b_in_ready !== 1'b1) begin
                errors++; $display("FAIL in_ready%0d got %b required 1", i, b_in_ready);
            end
            b_in_valid = 1'b1; b_in_data = DATA_W'(8'hA0 + i);
            sb.push_back(DATA_W'(8'hA0 + i));
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        checks++;
        if (b_done !== 1'b1 || b_busy !== 1'b0 || b_in_ready !== 1'b0) begin
            errors++; $display("FAIL in_done got done=%b busy=%b ready=%b required 1 0 0", b_done, b_busy, b_in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            a_read(ADDR_W'(13'h1FFE + i), d, v);
            checks++;
            if (d !== sb.pop_front()) begin
                errors++; $display("FAIL in_wrap_mem%0d got %h required %h", i, d, 8'hA0 + i);
            end
        end
    endtask

    task automatic test_abort();
        logic [DATA_W-1:0] d; logic v;
        for (int i = 0; i < 8; i++) a_write(ADDR_W'(13'h200 + i), 8'hEE);
        start_burst(1'b1, 13'h0200, 14'd8);
        for (int i = 0; i < 3; i++) begin
            b_in_valid = 1'b1; b_in_data = DATA_W'(8'h31 + i);
            b_abort = (i == 2);
            @(negedge clk);
        end
        b_abort = 1'b0; b_in_valid = 1'b0;
        checks++;
        if (b_busy !== 1'b0 || b_in_ready !== 1'b0 || b_done !== 1'b0) begin
            errors++; $display("FAIL abort_in got busy=%b ready=%b done=%b required 0 0 0", b_busy, b_in_ready, b_done);
        end
        @(negedge clk);
        checks++;
        if (b_done !== 1'b0) begin
            errors++; $display("FAIL abort_no_done got %b required 0", b_done);
        end
        for (int i = 0; i < 8; i++) sb.push_back(i < 3 ? DATA_W'(8'h31 + i) : 8'hEE);
        for (int i = 0; i < 8; i++) begin
            a_read(ADDR_W'(13'h200 + i), d, v);
            checks++;
            if (d !== sb.pop_front()) begin
                errors++; $display("FAIL abort_mem%0d got %h required %s", i, d, i < 3 ? "committed" : "ee");
            end
        end
        b_out_ready = 1'b0;
        start_burst(1'b0, 13'h0010, 14'd8);
        repeat (2) @(negedge clk);
        b_abort = 1'b1;
        @(negedge clk);
        b_abort = 1'b0;
        repeat (2) begin
            checks++;
            if (b_out_valid !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0) begin
                errors++; $display("FAIL abort_out got valid=%b busy=%b done=%b required 0 0 0", b_out_valid, b_busy, b_done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_collision();
        logic [DATA_W-1:0] d; logic v;
        a_write(13'h0101, 8'h11);
        start_burst(1'b1, 13'h0100, 14'd2);
        b_in_valid = 1'b1; b_in_data = 8'hBB;
        a_en = 1'b0; a_rw = 1'b0; a_addr = 13'h0100; a_din = 8'hAA;
        @(negedge clk);
        b_in_data = 8'h22;
        a_rw = 1'b1; a_addr = 13'h0101;
        @(negedge clk);
        a_en = 1'b1; b_in_valid = 1'b0;
        checks++;
        if (a_valid !== 1'b1 || a_dout !== 8'h11) begin
            errors++; $display("FAIL rw_collision got valid=%b data=%h required 1 11", a_valid, a_dout);
        end
        a_read(13'h0100, d, v);
        checks++;
        if (d !== 8'hAA) begin
            errors++; $display("FAIL ww_collision got %h required aa", d);
        end
        a_read(13'h0101, d, v);
        checks++;
        if (d !== 8'h22) begin
            errors++; $display("FAIL b_write_after got %h required 22", d);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [DATA_W-1:0] e;
        b_out_ready = 1'b0;
        start_burst(1'b0, 13'h0010, 14'd16);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_dout, a_valid, b_out_data, b_out_valid, b_in_ready, b_busy, b_done} !== '0) begin
            errors++; $display("FAIL reset_mid got out_valid=%b out_data=%h busy=%b required all 0",
                               b_out_valid, b_out_data, b_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb.push_back(8'h00); sb.push_back(8'h01);
        b_out_ready = 1'b1;
        start_burst(1'b0, 13'h0010, 14'd2);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (b_out_valid !== 1'b1 || b_out_data !== e) begin
                errors++; $display("FAIL post_reset_word%0d got valid=%b data=%h required 1 %h", i, b_out_valid, b_out_data, e);
            end
        end
        @(negedge clk);
        checks++;
        if (b_done !== 1'b1) begin
            errors++; $display("FAIL post_reset_done got %b required 1", b_done);
        end
    endtask

    initial begin
        rst_n = 1'b0; a_addr = '0; a_din = '0; a_rw = 1'b1; a_en = 1'b1;
        b_start = 1'b0; b_dir = 1'b0; b_base = '0; b_len = '0; b_abort = 1'b0;
        b_out_ready = 1'b0; b_in_data = '0; b_in_valid = 1'b0;
        test_reset();
        test_port_a();
        test_zero_len();
        test_out_burst();
        test_out_backpressure();
        test_in_wrap();
        test_abort();
        test_collision();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_dp_stream.md
# sram_dp_stream

Parametrised dual-port sector buffer, successor to the single-port 8 KiB SRAM. Port A keeps the host-side random-access interface: active-low enable, rw select, 1-cycle read. Port B adds a burst streaming engine that moves a programmed run of words between RAM and the floppy datapath with valid/ready handshakes, modulo address wrap, abort and done signalling. Sits between the host bus decoder and the track encoder/decoder.

## Interface
- DATA_W, 8, word width
- ADDR_W, 13, address width; depth = 2**ADDR_W
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_addr  in  ADDR_W  port A address
- a_din  in  DATA_W  port A write data
- a_rw  in  1  1 = read, 0 = write
- a_en  in  1  active-low port A enable
- a_dout  out  DATA_W  port A read data, held until next read
- a_valid  out  1  pulses 1 cycle when a_dout updated
- b_start  in  1  1-cycle pulse; starts a burst (ignored while b_busy)
- b_dir  in  1  0 = RAM to stream (out), 1 = stream to RAM (in); sampled with b_start
- b_base  in  ADDR_W  first burst address, sampled with b_start
- b_len  in  ADDR_W+1  word count, sampled with b_start; max 2**ADDR_W
- b_abort  in  1  terminates burst
- b_out_data  out  DATA_W  outbound word
- b_out_valid  out  1  outbound word present
- b_out_ready  in  1  consumer accepts
- b_in_data  in  DATA_W  inbound word
- b_in_valid  in  1  producer offers word
- b_in_ready  out  1  engine accepts
- b_busy  out  1  burst in progress
- b_done  out  1  1-cycle pulse at normal burst completion

## Operation
- Reset: a_dout=0, a_valid=0, b_out_data=0, b_out_valid=0, b_in_ready=0, b_busy=0, b_done=0, state IDLE, skid FIFO empty. RAM contents not reset. No tri-state outputs anywhere.
- Port A: on edge with a_en=0: a_rw=1 gives a_dout<=RAM[a_addr], a_valid<=1; a_rw=0 writes a_din, a_dout unchanged. a_en=1: no access, a_valid<=0.
- Engine states: IDLE, RUN, DRAIN.
- IDLE -> RUN on b_start with b_len!=0; latch dir, address pointer=b_base, remaining=b_len; b_busy<=1.
- b_start with b_len=0: no transfer; b_done pulses next cycle, b_busy stays 0.
- Out mode RUN: issue RAM read at pointer whenever occupancy (FIFO entries + in-flight read) < 2 and reads remain; pointer increments per read. Read data enters 2-entry skid FIFO; head drives b_out_data/b_out_valid. After last read issued -> DRAIN; DRAIN -> IDLE on final handshake.
- In mode RUN: b_in_ready=1; each b_in_valid&b_in_ready writes b_in_data at pointer, pointer++, remaining--; last handshake -> IDLE.
- Pointer arithmetic modulo 2**ADDR_W; b_base+b_len past top wraps to 0.
- b_abort (any non-IDLE state): next edge -> IDLE, FIFO flushed, b_out_valid/b_in_ready/b_busy <=0, no b_done. Handshake in abort cycle still completes (write committed / word consumed). Abort in IDLE ignored.
- Collisions: A and B write same address same cycle -> port A data stored. Read and write same address same cycle (either port pair) -> read returns old data.

## Timing
- Port A read latency 1 cycle; back-to-back reads at full rate.
- Out: b_start at edge 0 -> first read edge 1 -> b_out_valid=1 after edge 2. With b_out_ready held 1, one word per cycle, no bubbles.
- b_out_ready low: b_out_valid/b_out_data hold stable; no word lost or duplicated.
- In: b_in_ready=1 after edge 0; one word per cycle sustained.
- b_done=1 for exactly the cycle after the final handshake; b_busy falls in that same cycle. New b_start accepted in the b_done cycle.

## Structure
- Package sram_stream_pkg: state enum (IDLE, RUN, DRAIN), DIR_OUT=0/DIR_IN=1 constants.
- Sub-module sram_dp_core: raw true-dual-port array (two synchronous ports, read-old-data, port A write priority); engine, skid FIFO and port A registers live in sram_dp_stream.

## Test plan
- Reset mid-burst: assert rst_n=0 during out burst -> all outputs 0 immediately, b_busy=0; fresh burst after release works.
- Port A write 0x5A at 0x1FFF, read back -> a_dout=0x5A, a_valid 1 cycle after read edge.
- Preload 0..15 at 0x10, out burst base=0x10 len=16, ready=1 -> data 0..15 on consecutive cycles, first valid 2 cycles after start, b_done once.
- Same burst with ready toggling randomly -> identical sequence, no drops or duplicates.
- In burst base=0x1FFE len=4 data A0..A3 -> RAM[1FFE]=A0, [1FFF]=A1, [0000]=A2, [0001]=A3.
- Abort after 3 of 8 in-words -> 3 writes committed, b_done never pulses; A and B write 0x0100 same cycle -> port A data read back.
